// File: rtl/dsp_pkg.sv
// Shared DSP helpers: constant-function clog2 and the minimum accumulator
// width needed to sum LEN full-precision WIDTH x WIDTH products without overflow.
package dsp_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >>> 1;
            end
        end
        return r;
    endfunction

    // Full product width plus one growth bit per doubling of the term count.
    function automatic int acc_min_width(input int width, input int len);
        return 2 * width + clog2(len);
    endfunction

endpackage

// File: rtl/dsp_mul_pipe.sv
// Two-stage registered signed multiply (operand register, product register)
// with a shared clock enable and per-stage valid bits.
module dsp_mul_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_ce,
    input  logic                      i_clear,
    input  logic                      i_valid,
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic                      o_valid,
    output logic signed [2*WIDTH-1:0] o_prod
);

    logic                      r_v1;
    logic                      r_v2;
    logic signed [2*WIDTH-1:0] w_prod;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (i_clear) begin
            // i_valid is already qualified by the enable, so a same-cycle
            // accept survives the clear and starts the next frame.
            r_v1 <= i_valid;
            r_v2 <= 1'b0;
        end else if (i_ce) begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
        end
    end

    generate
        if (WIDTH <= 16) begin : g_mac16
            // Enable-only input and output registers fold into one SB_MAC16
            // (A/B hold registers plus the 32-bit output pipeline register).
            logic signed [WIDTH-1:0]   r_a;
            logic signed [WIDTH-1:0]   r_b;
            logic signed [2*WIDTH-1:0] r_p;

            // NOTE: datapath registers carry no reset; the valid bits above
            // qualify them, which keeps them mappable into the DSP tile.
            always_ff @(posedge clock) begin
                if (i_ce) begin
                    r_a <= i_a;
                    r_b <= i_b;
                    r_p <= r_a * r_b;
                end
            end
            assign w_prod = r_p;
        end else begin : g_fabric
            (* use_dsp = "no" *) logic signed [WIDTH-1:0]   r_a;
            (* use_dsp = "no" *) logic signed [WIDTH-1:0]   r_b;
            (* use_dsp = "no" *) logic signed [2*WIDTH-1:0] r_p;

            always_ff @(posedge clock) begin
                if (i_ce) begin
                    r_a <= i_a;
                    r_b <= i_b;
                    r_p <= r_a * r_b;
                end
            end
            assign w_prod = r_p;
        end
    endgenerate

    assign o_valid = r_v2;
    assign o_prod  = w_prod;

endmodule

// File: rtl/dsp_mac_dot.sv
// Streaming signed dot product: LEN products per frame are accumulated and the
// (optionally saturated) 2*WIDTH-bit sum is presented on a valid/ready output.
module dsp_mac_dot
    import dsp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LEN       = 64,
    parameter int ACC_WIDTH = 40,
    parameter int SAT       = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] result,
    output logic                      sat
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (LEN > 1) ? clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    generate
        if (LEN < 1) begin : g_len_check
            $error("dsp_mac_dot: LEN must be at least 1");
        end
        if (ACC_WIDTH < acc_min_width(WIDTH, LEN)) begin : g_acc_width_check
            $error("dsp_mac_dot: ACC_WIDTH is smaller than 2*WIDTH + clog2(LEN)");
        end
    endgenerate

    logic                     w_ce;
    logic                     w_accept;
    logic                     w_p_valid;
    logic                     w_last;
    logic                     w_ovf;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_WIDTH-1:0] w_p_ext;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic [ACC_WIDTH-PW:0]    w_hi;
    logic signed [PW-1:0]     w_res_next;
    logic                     w_sat_next;

    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [PW-1:0]     r_result;
    logic                     r_sat;
    logic                     r_out_valid;

    // The whole pipeline freezes only while a result waits on the consumer.
    assign w_ce     = !(r_out_valid && !out_ready);
    assign in_ready = w_ce;
    assign w_accept = in_valid && w_ce;

    dsp_mul_pipe #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .i_ce    (w_ce),
        .i_clear (clear),
        .i_valid (w_accept),
        .i_a     (a),
        .i_b     (b),
        .o_valid (w_p_valid),
        .o_prod  (w_prod)
    );

    assign w_p_ext    = ACC_WIDTH'(w_prod);
    assign w_acc_next = (r_cnt == '0) ? w_p_ext : r_acc + w_p_ext;
    assign w_last     = (r_cnt == LAST);

    // The sum fits in PW bits only when all bits from PW-1 upward agree.
    assign w_hi  = w_acc_next[ACC_WIDTH-1:PW-1];
    assign w_ovf = !((&w_hi) || !(|w_hi));

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_res_next = w_acc_next[PW-1:0];
        w_sat_next = 1'b0;
        if (SAT != 0 && w_ovf) begin
            w_sat_next = 1'b1;
            w_res_next = w_acc_next[ACC_WIDTH-1] ? {1'b1, {(PW-1){1'b0}}}
                                                 : {1'b0, {(PW-1){1'b1}}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_ce) begin
            // With ce high any pending result is being taken this cycle, so
            // out_valid simply follows frame completion (no bubble between frames).
            r_out_valid <= w_p_valid && w_last;
            if (w_p_valid) begin
                r_acc <= w_acc_next;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_res_next;
                    r_sat    <= w_sat_next;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign sat       = r_sat;

endmodule

// File: tb/tb_dsp_mac_dot.sv
// Self-checking bench for dsp_mac_dot: table-driven frames plus hand-written
// latency, stall, clear, reset and LEN=1 sequences, scored against a queue model.
module tb_dsp_mac_dot;

    localparam int LEN = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] res;
        logic        sat;
    } exp_t;

    typedef struct {
        int          va;
        int          vb;
        logic [31:0] res;
        logic        sat;
        logic [31:0] res_ns;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic               clear;
    logic               in_valid;
    logic               out_ready;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               in_ready;
    logic               out_valid;
    logic signed [31:0] result;
    logic               sat;

    logic               ns_in_ready;
    logic               ns_out_valid;
    logic signed [31:0] ns_result;
    logic               ns_sat;

    logic               l1_in_valid;
    logic               l1_out_ready;
    logic signed [15:0] l1_a;
    logic signed [15:0] l1_b;
    logic               l1_in_ready;
    logic               l1_out_valid;
    logic signed [31:0] l1_result;
    logic               l1_sat;

    dsp_mac_dot #(.WIDTH(16), .LEN(LEN), .ACC_WIDTH(40), .SAT(1)) u_dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat(sat)
    );

    dsp_mac_dot #(.WIDTH(16), .LEN(LEN), .ACC_WIDTH(40), .SAT(0)) u_dut_ns (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(ns_in_ready), .a(a), .b(b),
        .out_valid(ns_out_valid), .out_ready(out_ready), .result(ns_result), .sat(ns_sat)
    );

    dsp_mac_dot #(.WIDTH(16), .LEN(1), .ACC_WIDTH(40), .SAT(1)) u_dut_l1 (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(l1_in_valid), .in_ready(l1_in_ready), .a(l1_a), .b(l1_b),
        .out_valid(l1_out_valid), .out_ready(l1_out_ready), .result(l1_result), .sat(l1_sat)
    );

    int     n_total = 0;
    int     n_pass  = 0;
    exp_t   q_exp[$];
    exp_t   q_ns[$];
    longint m_sum   = 0;
    int     m_cnt   = 0;
    bit     use_tab = 0;
    exp_t   tab_e;
    exp_t   tab_ens;
    bit     accepted = 0;
    bit     hold_ready_low = 0;
    int     stall_left = 0;
    vec_t   tab[6];

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input longint s, input bit do_sat);
        exp_t e;
        e.res = s[31:0];
        e.sat = 1'b0;
        if (do_sat && s > SMAX) begin
            e.res = 32'h7FFF_FFFF;
            e.sat = 1'b1;
        end else if (do_sat && s < SMIN) begin
            e.res = 32'h8000_0000;
            e.sat = 1'b1;
        end
        return e;
    endfunction

    // One clock cycle: set out_ready, score handshakes, advance to just after the edge.
    task automatic cycle();
        bit   in_stall = 0;
        exp_t e;
        if (hold_ready_low) out_ready = 1'b0;
        else if (stall_left > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_left--;
            in_stall = 1;
        end else out_ready = 1'b1;
        #1;
        accepted = 0;
        if (reset) begin
            q_exp.delete();
            q_ns.delete();
            m_sum = 0;
            m_cnt = 0;
        end else begin
            if (in_stall) begin
                check(in_ready == 1'b0, "stall_in_ready", 64'(in_ready), 64'd0);
                if (q_exp.size() != 0)
                    check(out_valid && result == q_exp[0].res, "stall_hold",
                          64'(result), 64'(q_exp[0].res));
            end
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) check(1'b0, "unexpected_output", 64'(result), 64'd0);
                else begin
                    e = q_exp.pop_front();
                    check(result == e.res && sat == e.sat, "frame_sat",
                          {31'd0, sat, result}, {31'd0, e.sat, e.res});
                end
            end
            if (ns_out_valid && out_ready) begin
                if (q_ns.size() == 0) check(1'b0, "unexpected_output_ns", 64'(ns_result), 64'd0);
                else begin
                    e = q_ns.pop_front();
                    check(ns_result == e.res && ns_sat == e.sat, "frame_trunc",
                          {31'd0, ns_sat, ns_result}, {31'd0, e.sat, e.res});
                end
            end
            if (clear) begin
                m_sum = 0;
                m_cnt = 0;
            end
            if (in_valid && in_ready) begin
                accepted = 1;
                m_sum += longint'(a) * longint'(b);
                m_cnt++;
                if (m_cnt == LEN) begin
                    q_exp.push_back(use_tab ? tab_e : model(m_sum, 1'b1));
                    q_ns.push_back(use_tab ? tab_ens : model(m_sum, 1'b0));
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int va, input int vb);
        bit got = 0;
        a = 16'(va);
        b = 16'(vb);
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            got = accepted;
        end
        if (!got) check(1'b0, "send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && (q_exp.size() != 0 || q_ns.size() != 0); k++) cycle();
        check(q_exp.size() == 0 && q_ns.size() == 0, "drain",
              64'(q_exp.size() + q_ns.size()), 64'd0);
    endtask

    initial begin
        tab[0] = '{1000,   2000,   32'h007A_1200, 1'b0, 32'h007A_1200};
        tab[1] = '{-32768, -32768, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000};
        tab[2] = '{-32768, 32767,  32'h8000_0000, 1'b1, 32'h0002_0000};
        tab[3] = '{32767,  32767,  32'h7FFF_FFFF, 1'b1, 32'hFFFC_0004};
        tab[4] = '{-1,     1,      32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC};
        tab[5] = '{100,    -200,   32'hFFFE_C780, 1'b0, 32'hFFFE_C780};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        l1_in_valid = 1'b0; l1_out_ready = 1'b1; l1_a = '0; l1_b = '0;

        // Reset state and ready in the first cycle after reset.
        cycle();
        cycle();
        check(out_valid == 1'b0 && result == 0 && sat == 1'b0, "reset_state",
              {31'd0, sat, result}, 64'd0);
        reset = 1'b0;
        check(in_ready == 1'b1, "ready_after_reset", 64'(in_ready), 64'd1);

        // Latency: out_valid three cycles after the fourth accept, for one cycle.
        for (int i = 0; i < LEN; i++) send(1000, 2000);
        in_valid = 1'b0;
        check(out_valid == 1'b0, "lat_t1", 64'(out_valid), 64'd0);
        cycle();
        check(out_valid == 1'b0, "lat_t2", 64'(out_valid), 64'd0);
        cycle();
        check(out_valid == 1'b1 && result == 32'sd8000000, "lat_t3",
              {31'd0, out_valid, result}, {31'd1, 32'd8000000});
        cycle();
        check(out_valid == 1'b0, "lat_t4", 64'(out_valid), 64'd0);
        drain();

        // Table-driven frames against fixed expected results.
        use_tab = 1;
        for (int r = 0; r < 6; r++) begin
            tab_e   = '{tab[r].res, tab[r].sat};
            tab_ens = '{tab[r].res_ns, 1'b0};
            for (int i = 0; i < LEN; i++) send(tab[r].va, tab[r].vb);
            drain();
        end
        use_tab = 0;

        // Consumer stalls for five cycles while two frames stream back to back.
        stall_left = 5;
        for (int i = 0; i < 2 * LEN; i++) send(i * 1111 - 4000, 3000 - i * 777);
        drain();
        check(stall_left == 0, "stall_applied", 64'(stall_left), 64'd0);

        // Clear after two samples; the sample accepted with clear starts the new frame.
        send(9, 9);
        send(9, 9);
        a = 16'sd3; b = 16'sd5; in_valid = 1'b1; clear = 1'b1;
        cycle();
        clear = 1'b0;
        check(accepted == 1'b1, "clear_accept", 64'(accepted), 64'd1);
        for (int i = 0; i < LEN - 1; i++) send(3, 5);
        drain();

        // Reset with a result pending and partial sums in flight.
        hold_ready_low = 1;
        for (int i = 0; i < LEN; i++) send(100, 100);
        send(5, 5);
        send(5, 5);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) cycle();
        check(out_valid == 1'b1, "pending_before_reset", 64'(out_valid), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        hold_ready_low = 0;
        check(out_valid == 1'b0 && result == 0 && sat == 1'b0, "mid_reset",
              {31'd0, out_valid, result}, 64'd0);
        for (int i = 0; i < LEN; i++) send(2, -3);
        drain();

        // LEN=1: every product is a frame; result -63 every cycle after the fill.
        l1_a = 16'sd7; l1_b = -16'sd9; l1_in_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k < 3)
                check(l1_out_valid == 1'b0, "len1_fill", 64'(l1_out_valid), 64'd0);
            else
                check(l1_out_valid == 1'b1 && l1_result == -32'sd63 && l1_sat == 1'b0,
                      "len1_stream", {31'd0, l1_out_valid, l1_result},
                      {31'd1, 32'hFFFF_FFC1});
        end
        l1_in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dsp_mac_dot.md
DSP_MAC_DOT -- requirements
Module: dsp_mac_dot

Interface
REQ-001 The block SHALL expose these parameters:
- WIDTH, default 16: signed operand width.
- LEN, default 64: products summed per frame, LEN >= 1.
- ACC_WIDTH, default 40: accumulator width.
- SAT, default 1: 1 saturates the result, 0 truncates it.

REQ-002 The block SHALL expose these ports:
- clock, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- clear, in, 1: abort the current frame.
- in_valid, in, 1: operand pair present.
- in_ready, out, 1: block accepts operands.
- a, in, WIDTH: signed operand A.
- b, in, WIDTH: signed operand B.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- result, out, 2*WIDTH: signed dot product.
- sat, out, 1: result was clipped.

REQ-003 Reset SHALL be synchronous and active-high on port reset, and clock SHALL be the only clock.

Function
REQ-004 An operand pair SHALL be accepted in a cycle with in_valid && in_ready.
REQ-005 The pipeline SHALL have three stages: operand register, product register (full 2*WIDTH signed product), then accumulator/result register.
REQ-006 A global enable ce = !(out_valid && !out_ready) SHALL advance all stages; in_ready SHALL equal ce.
REQ-007 While ce = 0, every stage, the counter and the outputs SHALL hold their values, and no accepted sample SHALL be lost.
REQ-008 A sample counter SHALL count products entering the accumulator, from 0 to LEN-1.
- The first product of a frame loads the accumulator; later products add to it.
- The product at count LEN-1 completes the frame and the counter wraps to 0.
REQ-009 Products SHALL be sign-extended to ACC_WIDTH before accumulation.
REQ-010 On frame completion, result and sat SHALL register in the same cycle and out_valid SHALL rise.
- Latency: the last sample accepted in cycle t gives out_valid in cycle t+3 when no stalls occur.
REQ-011 out_valid SHALL fall in the cycle after the cycle with out_valid && out_ready, unless that cycle completes another frame, in which case out_valid stays high with new data (back-to-back frames, no bubble).
REQ-012 With SAT=1, a sum above 2^(2W-1)-1 or below -2^(2W-1) SHALL be clipped to that bound and sat=1; otherwise sat=0.
REQ-013 With SAT=0, result SHALL be the low 2*WIDTH accumulator bits and sat SHALL be 0.
REQ-014 clear SHALL act on the next edge regardless of ce:
- zero the counter;
- invalidate the operand and product stages;
- drop out_valid.
- The sample accepted in the same cycle as clear becomes the first sample of the new frame.
REQ-015 With LEN=1, every product SHALL be a complete frame.

Reset
REQ-016 Reset SHALL clear stage valid bits, counter, accumulator, result (0), sat (0) and out_valid (0).
REQ-017 in_ready SHALL be 1 in the first cycle after reset.
REQ-018 Reset asserted mid-frame SHALL discard all partial sums and in-flight samples.
REQ-019 Reset SHALL take priority over clear and the handshakes.

Structure
REQ-020 A shared package dsp_pkg SHALL hold clog2 and the ACC_WIDTH minimum-width function.
REQ-021 An elaboration check SHALL fail if ACC_WIDTH < 2*WIDTH + clog2(LEN).
REQ-022 One sub-module, dsp_mul_pipe, SHALL provide the registered signed WIDTH x WIDTH multiply with enable (stages 1-2).
- It SHALL map to one SB_MAC16 when WIDTH <= 16 and to inferred logic otherwise.

Verification (WIDTH=16, LEN=4, SAT=1 unless stated)
REQ-023 Four pairs (1000, 2000) back-to-back, out_ready=1 -> result=8,000,000, sat=0, out_valid 3 cycles after the 4th accept, high for one cycle.
REQ-024 Four pairs (-32768, -32768) -> result=0x7FFFFFFF, sat=1; four pairs (-32768, 32767) -> result=0x80000000, sat=1; same stimulus with SAT=0 -> result = low 32 bits, sat=0.
REQ-025 out_ready=0 for 5 cycles while 8 pairs stream -> in_ready=0 and result held during the stall; both frame results delivered in order with none lost.
REQ-026 clear after 2 of 4 samples, then 4 pairs (3, 5) -> the only result is 60; no stale output.
REQ-027 Reset asserted mid-frame with out_valid pending -> out_valid=0 and result=0 next cycle; the following full frame is correct.
REQ-028 LEN=1 with a continuous stream (7, -9) -> result=-63 every cycle after the 3-cycle fill.
